// File: rtl/line_fifo_arbiter_pkg.sv
// Shared phase encoding and default sizing for the line FIFO arbiter.
package line_fifo_arbiter_pkg;
   localparam int LFA_DATA_WIDTH = 16;
   localparam int LFA_DEPTH      = 2048;

   typedef enum logic [1:0] {
      PH_LOAD  = 2'd0,
      PH_SOLVE = 2'd1,
      PH_FLUSH = 2'd2
   } phase_e;
endpackage

// File: rtl/line_pass_counter.sv
// Tracks solver passes over the FIFO contents: pass length, reads so far,
// end-of-pass pulse and a saturating count of completed passes.
module line_pass_counter #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_go_i,
   input  logic             rd_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] occ_i,
   input  logic [CNT_W-1:0] occ_next_i,
   output logic             pass_done_o,
   output logic [7:0]       pass_count_o
);
   logic [CNT_W-1:0] pass_len_q, pass_len_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             done_q, done_d;
   logic [7:0]       cnt_q, cnt_d;

   always_comb begin
      pass_len_d = pass_len_q;
      rd_cnt_d   = rd_cnt_q;
      done_d     = 1'b0;
      cnt_d      = cnt_q;
      if (load_go_i) begin
         pass_len_d = occ_i;
         rd_cnt_d   = '0;
      end else if (rd_i) begin
         // An empty pass never completes, so pass_done stays quiet.
         if (pass_len_q != '0 && (rd_cnt_q + CNT_W'(1)) == pass_len_q) begin
            done_d     = 1'b1;
            rd_cnt_d   = '0;
            pass_len_d = occ_next_i;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
         end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
         end
      end
      if (clr_i) cnt_d = 8'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_len_q <= '0;
         rd_cnt_q   <= '0;
         done_q     <= 1'b0;
         cnt_q      <= 8'd0;
      end else begin
         pass_len_q <= pass_len_d;
         rd_cnt_q   <= rd_cnt_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
      end
   end

   assign pass_done_o  = done_q;
   assign pass_count_o = cnt_q;
endmodule

// File: rtl/line_fifo_arbiter.sv
// Arbitrates a shared line FIFO between parser (LOAD) and solver (SOLVE),
// drains it in FLUSH, and tracks occupancy, passes and sticky errors.
module line_fifo_arbiter
   import line_fifo_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = LFA_DATA_WIDTH,
   parameter int DEPTH      = LFA_DEPTH,
   localparam int CNT_W     = $clog2(DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p_wr_valid,
   input  logic [DATA_WIDTH-1:0] p_wr_data,
   output logic                  p_wr_ready,
   input  logic                  p_first_read,
   input  logic                  board_parsed,
   input  logic                  s_wr_valid,
   input  logic [DATA_WIDTH-1:0] s_wr_data,
   output logic                  s_wr_ready,
   input  logic                  s_rd_req,
   input  logic                  solved,
   output logic [DATA_WIDTH-1:0] fifo_din,
   output logic                  fifo_wr_en,
   output logic                  fifo_rd_en,
   input  logic                  fifo_full,
   input  logic                  fifo_empty,
   output logic [1:0]            phase,
   output logic [CNT_W-1:0]      occupancy,
   output logic                  pass_done,
   output logic [7:0]            pass_count,
   output logic [1:0]            err
);
   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [1:0]       err_q, err_d;

   logic in_load, in_solve, in_flush;
   logic rd_req, load_go, flush_done, wr_blocked;

   assign in_load  = (phase_q == PH_LOAD);
   assign in_solve = (phase_q == PH_SOLVE);
   assign in_flush = (phase_q == PH_FLUSH);

   // Handshakes are gated by rst_n so they drop immediately on reset assertion.
   assign p_wr_ready = rst_n & in_load  & ~fifo_full;
   assign s_wr_ready = rst_n & in_solve & ~fifo_full;
   assign fifo_wr_en = (p_wr_valid & p_wr_ready) | (s_wr_valid & s_wr_ready);
   assign fifo_din   = in_solve ? s_wr_data : p_wr_data;

   assign rd_req     = in_load ? p_first_read : (in_solve ? s_rd_req : 1'b1);
   assign fifo_rd_en = rst_n & rd_req & ~fifo_empty;

   assign load_go    = in_load & board_parsed;
   assign flush_done = in_flush & fifo_empty;
   assign wr_blocked = ((p_wr_valid & in_load) | (s_wr_valid & in_solve)) & fifo_full;

   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         PH_LOAD:  if (board_parsed) phase_d = PH_SOLVE;
         PH_SOLVE: if (solved)       phase_d = PH_FLUSH;
         PH_FLUSH: if (fifo_empty)   phase_d = PH_LOAD;
         default:                    phase_d = PH_LOAD;
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      if (fifo_wr_en && !fifo_rd_en && occ_q != CNT_W'(DEPTH)) occ_d = occ_q + CNT_W'(1);
      else if (fifo_rd_en && !fifo_wr_en && occ_q != '0)       occ_d = occ_q - CNT_W'(1);
   end

   always_comb begin
      err_d = err_q | {rd_req & fifo_empty & ~in_flush, wr_blocked};
      if (flush_done) err_d = 2'b00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_LOAD;
         occ_q   <= '0;
         err_q   <= 2'b00;
      end else begin
         phase_q <= phase_d;
         occ_q   <= occ_d;
         err_q   <= err_d;
      end
   end

   line_pass_counter #(.CNT_W(CNT_W)) u_pass (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_go_i    (load_go),
      .rd_i         (fifo_rd_en & in_solve),
      .clr_i        (flush_done),
      .occ_i        (occ_q),
      .occ_next_i   (occ_d),
      .pass_done_o  (pass_done),
      .pass_count_o (pass_count)
   );

   assign phase     = phase_q;
   assign occupancy = occ_q;
   assign err       = err_q;
endmodule

// File: tb/tb_line_fifo_arbiter.sv
// Directed bench for line_fifo_arbiter with a behavioural external FIFO count model.
module tb_line_fifo_arbiter;
   localparam int DW    = 16;
   localparam int DEPTH = 2048;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          p_wr_valid, p_first_read, board_parsed;
   logic [DW-1:0] p_wr_data, s_wr_data;
   logic          s_wr_valid, s_rd_req, solved;
   logic          p_wr_ready, s_wr_ready;
   logic [DW-1:0] fifo_din;
   logic          fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
   logic [1:0]    phase;
   logic [CW-1:0] occupancy;
   logic          pass_done;
   logic [7:0]    pass_count;
   logic [1:0]    err;

   logic force_full;
   int   mcnt;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_rd;

   always #5 clk = ~clk;

   // External FIFO stand-in: only its fill level matters to the arbiter.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mcnt <= 0;
      else        mcnt <= mcnt + int'(fifo_wr_en) - int'(fifo_rd_en);
   end
   assign fifo_empty = (mcnt == 0);
   assign fifo_full  = force_full || (mcnt >= DEPTH);

   line_fifo_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p_wr_valid   (p_wr_valid),
      .p_wr_data    (p_wr_data),
      .p_wr_ready   (p_wr_ready),
      .p_first_read (p_first_read),
      .board_parsed (board_parsed),
      .s_wr_valid   (s_wr_valid),
      .s_wr_data    (s_wr_data),
      .s_wr_ready   (s_wr_ready),
      .s_rd_req     (s_rd_req),
      .solved       (solved),
      .fifo_din     (fifo_din),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .phase        (phase),
      .occupancy    (occupancy),
      .pass_done    (pass_done),
      .pass_count   (pass_count),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; force_full = 1'b0;
      p_wr_valid = 0; p_wr_data = '0; p_first_read = 0; board_parsed = 0;
      s_wr_valid = 0; s_wr_data = '0; s_rd_req = 0; solved = 0;
      #12;
      chk("rst_phase", phase, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_pcnt", pass_count, 0);
      chk("rst_err", err, 0);
      chk("rst_pdone", pass_done, 0);
      chk("rst_pready", p_wr_ready, 0);
      @(negedge clk); rst_n = 1'b1;
      tick;

      // LOAD: five parser words
      for (int i = 0; i < 5; i++) begin
         p_wr_valid = 1; p_wr_data = DW'(16'h00A0 + i);
         #1;
         chk("load_ready", p_wr_ready, 1);
         chk("load_wren", fifo_wr_en, 1);
         chk("load_din", fifo_din, 32'h00A0 + i);
         tick;
      end
      p_wr_valid = 0;
      chk("load_occ", occupancy, 5);
      board_parsed = 1; tick; board_parsed = 0;
      chk("parsed_phase", phase, 1);
      chk("parsed_occ", occupancy, 5);
      chk("parsed_plen", dut.u_pass.pass_len_q, 5);

      // Pass: 5 reads, 3 write-backs overlapping the first reads
      for (int i = 0; i < 5; i++) begin
         s_rd_req = 1; s_wr_valid = (i < 3); s_wr_data = DW'(16'h00B0 + i);
         #1;
         chk("pass_rden", fifo_rd_en, 1);
         chk("pass_early_done", pass_done, 0);
         if (i == 0) chk("solve_din", fifo_din, 32'h00B0);
         tick;
      end
      s_rd_req = 0; s_wr_valid = 0;
      chk("pass_done", pass_done, 1);
      chk("pass_cnt1", pass_count, 1);
      chk("pass_occ", occupancy, 3);
      board_parsed = 1; tick; board_parsed = 0;
      chk("pass_done_drop", pass_done, 0);
      chk("stray_parsed_phase", phase, 1);
      chk("next_plen", dut.u_pass.pass_len_q, 3);

      // Simultaneous read and write at occupancy 4
      s_wr_valid = 1; tick; s_wr_valid = 0;
      chk("sim_occ_pre", occupancy, 4);
      for (int i = 0; i < 4; i++) begin
         s_rd_req = 1; s_wr_valid = 1;
         #1;
         chk("sim_rden", fifo_rd_en, 1);
         chk("sim_wren", fifo_wr_en, 1);
         tick;
         chk("sim_occ", occupancy, 4);
      end
      s_rd_req = 0; s_wr_valid = 0;
      chk("sim_pcnt", pass_count, 2);

      // Flush from occupancy 7
      s_wr_valid = 1; tick; tick; tick; s_wr_valid = 0;
      chk("pre_flush_occ", occupancy, 7);
      chk("pre_flush_err", err, 0);
      solved = 1; tick; solved = 0;
      chk("flush_phase", phase, 2);
      n_rd = 0;
      for (int k = 0; k < 50 && phase == 2'd2; k++) begin
         if (fifo_rd_en) n_rd++;
         tick;
      end
      chk("flush_reads", n_rd, 7);
      chk("flush_to_load", phase, 0);
      chk("flush_err", err, 0);
      chk("flush_pcnt", pass_count, 0);
      chk("flush_occ", occupancy, 0);

      // Full in LOAD
      force_full = 1; p_wr_valid = 1;
      #1;
      chk("full_pready", p_wr_ready, 0);
      chk("full_wren", fifo_wr_en, 0);
      tick;
      chk("full_err0", err, 1);
      p_wr_valid = 0; s_wr_valid = 1;
      #1;
      chk("full_sready", s_wr_ready, 0);
      tick;
      chk("nonowner_err", err, 1);
      s_wr_valid = 0; force_full = 0;
      solved = 1; tick; solved = 0;
      chk("stray_solved", phase, 0);
      p_first_read = 1;
      #1;
      chk("empty_rden", fifo_rd_en, 0);
      tick; p_first_read = 0;
      chk("empty_err1", err, 3);

      // Reset mid-SOLVE at occupancy 9
      for (int i = 0; i < 9; i++) begin
         p_wr_valid = 1; p_wr_data = DW'(i); tick;
      end
      p_wr_valid = 0;
      board_parsed = 1; tick; board_parsed = 0;
      chk("rs_phase", phase, 1);
      chk("rs_occ", occupancy, 9);
      chk("rs_err", err, 3);
      s_wr_valid = 1; s_rd_req = 1;
      #2; rst_n = 1'b0; #1;
      chk("ar_phase", phase, 0);
      chk("ar_occ", occupancy, 0);
      chk("ar_err", err, 0);
      chk("ar_pcnt", pass_count, 0);
      chk("ar_pdone", pass_done, 0);
      chk("ar_sready", s_wr_ready, 0);
      chk("ar_wren", fifo_wr_en, 0);
      chk("ar_rden", fifo_rd_en, 0);
      chk("ar_plen", dut.u_pass.pass_len_q, 0);
      s_wr_valid = 0; s_rd_req = 0;
      @(negedge clk); rst_n = 1'b1;
      tick;
      chk("post_rst_phase", phase, 0);
      chk("post_rst_occ", occupancy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
